// File: rtl/ntt_job_arbiter.sv
// ntt_job_arbiter: shares one NTT wrapper between two requesters.
// Grants are round-robin. A job keeps the unit from ntt_start until the
// wrapper finishes (or the run watchdog expires). Two idle gap cycles
// follow before the unit can be granted again. Memory traffic is routed
// combinationally between the wrapper and the current owner.
module ntt_job_arbiter #(
  parameter int LOGQ        = 64,
  parameter int LOGN        = 12,
  parameter int AW          = ((LOGN < 9) ? 10 : LOGN),
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_intt,
  output logic [1:0]      req_grant,
  output logic [1:0]      req_done,
  output logic [AW-1:0]   req_rd_addr,
  output logic [AW-1:0]   req_wr_addr,
  output logic [1:0]      req_wea,
  input  logic [LOGQ-1:0] req_din0,
  input  logic [LOGQ-1:0] req_din1,
  output logic [LOGQ-1:0] req_dout,
  output logic            ntt_start,
  output logic            ntt_intt,
  input  logic [AW-1:0]   ntt_rd_addr,
  input  logic [AW-1:0]   ntt_wr_addr,
  input  logic            ntt_wea,
  input  logic [LOGQ-1:0] ntt_dout,
  input  logic            ntt_finish,
  output logic [LOGQ-1:0] ntt_din,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Last RUN cycle index; reaching it without a finish edge aborts the job.
  localparam logic [31:0] RUN_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [1:0]  grant_q;
  logic [1:0]  done_q;
  logic        start_q;
  logic        intt_q;
  logic        busy_q;
  logic        tmo_q;
  logic        rr_pri;     // requester index that wins a tie
  logic [31:0] run_cnt;
  logic        gap_cnt;
  logic        fin_q;      // previous-cycle ntt_finish, for edge detection

  logic        pick_idx;
  logic        fin_rise;
  logic        run_expired;

  // Tie-break toward rr_pri; otherwise take whichever requester is valid.
  always_comb begin
    pick_idx = rr_pri;
    if (!req_valid[rr_pri]) begin
      pick_idx = ~rr_pri;
    end
  end

  // A finish that was already high on RUN entry has fin_q set, so it never
  // looks like a fresh edge.
  assign fin_rise    = ntt_finish & ~fin_q;
  assign run_expired = (run_cnt == RUN_LAST);

  // Job sequencing: IDLE grants, RUN waits for finish or watchdog, GAP holds
  // the owner for two quiet cycles before releasing the unit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      start_q <= 1'b0;
      intt_q  <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rr_pri  <= 1'b0;
      run_cnt <= '0;
      gap_cnt <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      fin_q  <= ntt_finish;
      done_q <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state   <= RUN;
            grant_q <= {pick_idx, ~pick_idx};
            start_q <= 1'b1;
            intt_q  <= req_intt[pick_idx];
            busy_q  <= 1'b1;
            run_cnt <= '0;
          end
        end
        RUN: begin
          if (fin_rise || run_expired) begin
            state   <= GAP;
            start_q <= 1'b0;
            done_q  <= grant_q;
            rr_pri  <= ~grant_q[1];
            gap_cnt <= 1'b0;
            if (!fin_rise) begin
              tmo_q <= 1'b1;
            end
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
        end
        GAP: begin
          if (gap_cnt) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data back to the wrapper comes from the owner only.
  always_comb begin
    case (grant_q)
      2'b01:   ntt_din = req_din0;
      2'b10:   ntt_din = req_din1;
      default: ntt_din = '0;
    endcase
  end

  // Write strobes reach the owner only while the job is actually running.
  always_comb begin
    req_wea = 2'b00;
    if (state == RUN) begin
      req_wea = grant_q & {2{ntt_wea}};
    end
  end

  assign req_rd_addr = ntt_rd_addr;
  assign req_wr_addr = ntt_wr_addr;
  assign req_dout    = ntt_dout;

  assign req_grant   = grant_q;
  assign req_done    = done_q;
  assign ntt_start   = start_q;
  assign ntt_intt    = intt_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// Testbench for ntt_job_arbiter: a wrapper model drives ntt_finish, the
// stimulus queues the expected completion of every job, and a monitor
// checks each req_done pulse against the head of that queue.
module tb_ntt_job_arbiter;

  localparam int LOGQ = 64;
  localparam int AW   = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req_valid, req_intt;
  logic [LOGQ-1:0] req_din0, req_din1, ntt_dout;
  logic [AW-1:0]   ntt_rd_addr, ntt_wr_addr;
  logic            ntt_wea, ntt_finish;

  logic [1:0]      d_grant, d_done, d_wea, t_grant, t_done, t_wea;
  logic [AW-1:0]   d_rd, d_wr, t_rd, t_wr;
  logic [LOGQ-1:0] d_dout, d_din, t_dout, t_din;
  logic            d_start, d_intt, d_busy, d_to, t_start, t_intt, t_busy, t_to;

  // Main instance with default watchdog.
  ntt_job_arbiter #(.LOGQ(LOGQ), .LOGN(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_intt(req_intt),
    .req_grant(d_grant), .req_done(d_done), .req_rd_addr(d_rd),
    .req_wr_addr(d_wr), .req_wea(d_wea), .req_din0(req_din0),
    .req_din1(req_din1), .req_dout(d_dout), .ntt_start(d_start),
    .ntt_intt(d_intt), .ntt_rd_addr(ntt_rd_addr), .ntt_wr_addr(ntt_wr_addr),
    .ntt_wea(ntt_wea), .ntt_dout(ntt_dout), .ntt_finish(ntt_finish),
    .ntt_din(d_din), .busy(d_busy), .timeout_err(d_to)
  );

  // Short-watchdog instance for the abort scenario.
  ntt_job_arbiter #(.LOGQ(LOGQ), .LOGN(12), .TIMEOUT_CYC(64)) dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_intt(req_intt),
    .req_grant(t_grant), .req_done(t_done), .req_rd_addr(t_rd),
    .req_wr_addr(t_wr), .req_wea(t_wea), .req_din0(req_din0),
    .req_din1(req_din1), .req_dout(t_dout), .ntt_start(t_start),
    .ntt_intt(t_intt), .ntt_rd_addr(ntt_rd_addr), .ntt_wr_addr(ntt_wr_addr),
    .ntt_wea(ntt_wea), .ntt_dout(ntt_dout), .ntt_finish(ntt_finish),
    .ntt_din(t_din), .busy(t_busy), .timeout_err(t_to)
  );

  logic sel_to;
  logic [1:0]      m_grant, m_done, m_wea;
  logic [AW-1:0]   m_rd, m_wr;
  logic [LOGQ-1:0] m_dout, m_din;
  logic            m_start, m_intt, m_busy, m_to;
  assign m_grant = sel_to ? t_grant : d_grant;
  assign m_done  = sel_to ? t_done  : d_done;
  assign m_wea   = sel_to ? t_wea   : d_wea;
  assign m_rd    = sel_to ? t_rd    : d_rd;
  assign m_wr    = sel_to ? t_wr    : d_wr;
  assign m_dout  = sel_to ? t_dout  : d_dout;
  assign m_din   = sel_to ? t_din   : d_din;
  assign m_start = sel_to ? t_start : d_start;
  assign m_intt  = sel_to ? t_intt  : d_intt;
  assign m_busy  = sel_to ? t_busy  : d_busy;
  assign m_to    = sel_to ? t_to    : d_to;

  // Wrapper model: finish rises fin_delay cycles after start goes high.
  // fin_mode 0 = model, 1 = stuck high, 2 = stuck low.
  int wc;
  int fin_delay;
  int fin_mode;
  always @(posedge clk) begin
    if (!m_start) wc <= 0;
    else          wc <= wc + 1;
  end
  assign ntt_finish = (fin_mode == 1) ? 1'b1 :
                      (fin_mode == 2) ? 1'b0 : (m_start && (wc >= fin_delay));

  typedef struct {
    logic [1:0] done;
    logic       intt;
    logic       to;
    int         run;
    int         gap;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] d, input logic i, input logic t,
                          input int r, input int g);
    exp_t e;
    e.done = d; e.intt = i; e.to = t; e.run = r; e.gap = g;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_qsize(input int sz, input int maxc, input string name);
    int k;
    k = 0;
    while (q.size() > sz && k < maxc) begin
      cyc(1);
      k++;
    end
    n_checks++;
    if (q.size() > sz) begin
      n_errors++;
      $display("FAIL %s: pending jobs %0d required %0d", name, q.size(), sz);
      while (q.size() > sz) void'(q.pop_back());
    end
  endtask

  // Monitor: measures start-high run length and start-low gap, and checks
  // every done pulse against the scoreboard.
  initial begin
    int runlen, lowcnt, last_gap;
    logic prev_start;
    logic [1:0] prev_done;
    exp_t e;
    runlen = 0; lowcnt = 1000; last_gap = -1;
    prev_start = 1'b0; prev_done = 2'b00;
    forever begin
      @(negedge clk);
      if (m_start) begin
        if (!prev_start) begin
          last_gap = lowcnt;
          runlen = 0;
        end
        runlen++;
      end else begin
        if (prev_start) lowcnt = 0;
        lowcnt++;
      end
      if (prev_done != 2'b00) chk("done_single_pulse", 64'(m_done), 64'd0);
      if (m_done != 2'b00) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=%b required none", m_done);
        end else begin
          e = q.pop_front();
          chk("done_vec", 64'(m_done), 64'(e.done));
          chk("grant_at_done", 64'(m_grant), 64'(e.done));
          chk("intt_held", 64'(m_intt), 64'(e.intt));
          chk("timeout_flag", 64'(m_to), 64'(e.to));
          chk("run_len", 64'(runlen), 64'(e.run));
          if (e.gap >= 0) chk("start_gap", 64'(last_gap), 64'(e.gap));
        end
      end
      prev_start = m_start;
      prev_done  = m_done;
    end
  end

  initial begin
    rst = 1'b0; req_valid = 2'b00; req_intt = 2'b00;
    req_din0 = 64'h1111; req_din1 = 64'h2222; ntt_dout = '0;
    ntt_rd_addr = '0; ntt_wr_addr = '0; ntt_wea = 1'b1;
    fin_mode = 0; fin_delay = 500; sel_to = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_grant", 64'(m_grant), 64'd0);
    chk("rst_done", 64'(m_done), 64'd0);
    chk("rst_start", 64'(m_start), 64'd0);
    chk("rst_intt", 64'(m_intt), 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_timeout", 64'(m_to), 64'd0);
    chk("idle_wea", 64'(m_wea), 64'd0);
    chk("idle_din", m_din, 64'd0);
    rst = 1'b1;
    cyc(1);

    // Single forward job from requester 0, 500-cycle wrapper
    push_exp(2'b01, 1'b0, 1'b0, 501, -1);
    req_valid = 2'b01;
    cyc(1);
    chk("j1_grant", 64'(m_grant), 64'd1);
    chk("j1_start", 64'(m_start), 64'd1);
    chk("j1_busy", 64'(m_busy), 64'd1);
    req_valid = 2'b00;
    cyc(10);
    ntt_rd_addr = 12'h3a5; ntt_wr_addr = 12'h5c3;
    ntt_dout = 64'hdead_beef_0123_4567; ntt_wea = 1'b1;
    req_din0 = 64'h0a0b_0c0d_1234_5678; req_din1 = 64'hffee_ddcc_8765_4321;
    #1;
    chk("route_rd", 64'(m_rd), 64'h3a5);
    chk("route_wr", 64'(m_wr), 64'h5c3);
    chk("route_dout", m_dout, 64'hdead_beef_0123_4567);
    chk("route_wea", 64'(m_wea), 64'd1);
    chk("route_din", m_din, 64'h0a0b_0c0d_1234_5678);
    ntt_wea = 1'b0;
    #1;
    chk("route_wea_low", 64'(m_wea), 64'd0);
    ntt_wea = 1'b1;
    wait_qsize(0, 700, "j1_complete");
    chk("gap0_start", 64'(m_start), 64'd0);
    chk("gap0_grant", 64'(m_grant), 64'd1);
    chk("gap0_wea", 64'(m_wea), 64'd0);
    cyc(1);
    chk("gap1_grant", 64'(m_grant), 64'd1);
    cyc(1);
    chk("idle_grant", 64'(m_grant), 64'd0);
    chk("idle_busy", 64'(m_busy), 64'd0);
    ntt_wea = 1'b0;

    // Back-to-back round robin after reset
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    fin_delay = 20;
    push_exp(2'b01, 1'b0, 1'b0, 21, -1);
    push_exp(2'b10, 1'b1, 1'b0, 21, 3);
    push_exp(2'b01, 1'b0, 1'b0, 21, 3);
    req_intt = 2'b10; req_valid = 2'b11;
    wait_qsize(1, 200, "rr_two_jobs");
    cyc(3);
    req_valid = 2'b00;
    wait_qsize(0, 200, "rr_third_job");
    cyc(3);

    // Owner 1 inverse job with mode toggling and valid dropped
    fin_delay = 60;
    req_intt = 2'b10; req_valid = 2'b10;
    push_exp(2'b10, 1'b1, 1'b0, 61, -1);
    cyc(1);
    chk("j4_grant", 64'(m_grant), 64'd2);
    chk("j4_intt", 64'(m_intt), 64'd1);
    cyc(5);
    req_intt = 2'b00; req_valid = 2'b00;
    cyc(5);
    chk("j4_intt_latched", 64'(m_intt), 64'd1);
    req_intt = 2'b10;
    cyc(3);
    req_intt = 2'b00;
    wait_qsize(0, 200, "j4_complete");
    cyc(3);

    // Finish stuck high before grant
    fin_mode = 1; fin_delay = 40;
    req_intt = 2'b00; req_valid = 2'b01;
    push_exp(2'b01, 1'b0, 1'b0, 41, -1);
    cyc(1);
    chk("j5_start", 64'(m_start), 64'd1);
    req_valid = 2'b00;
    cyc(20);
    chk("j5_no_early_done", 64'(q.size()), 64'd1);
    fin_mode = 0;
    wait_qsize(0, 200, "j5_complete");
    cyc(3);

    // Reset during RUN, then requester 1 alone
    fin_delay = 500;
    req_intt = 2'b10; req_valid = 2'b10;
    cyc(1);
    chk("j6_grant", 64'(m_grant), 64'd2);
    cyc(50);
    rst = 1'b0;
    req_intt = 2'b00;
    cyc(1);
    chk("midrst_grant", 64'(m_grant), 64'd0);
    chk("midrst_start", 64'(m_start), 64'd0);
    chk("midrst_busy", 64'(m_busy), 64'd0);
    chk("midrst_intt", 64'(m_intt), 64'd0);
    chk("midrst_done", 64'(m_done), 64'd0);
    fin_delay = 30;
    push_exp(2'b10, 1'b0, 1'b0, 31, -1);
    rst = 1'b1;
    cyc(1);
    chk("j7_grant", 64'(m_grant), 64'd2);
    req_valid = 2'b00;
    wait_qsize(0, 100, "j7_complete");
    cyc(3);

    // Watchdog abort on the 64-cycle instance, then the next job runs
    rst = 1'b0;
    sel_to = 1'b1; fin_mode = 2;
    cyc(2);
    rst = 1'b1;
    push_exp(2'b01, 1'b0, 1'b1, 64, -1);
    push_exp(2'b10, 1'b1, 1'b1, 11, 3);
    req_intt = 2'b10; req_valid = 2'b11;
    cyc(30);
    chk("to_not_yet", 64'(m_to), 64'd0);
    wait_qsize(1, 200, "to_abort");
    fin_mode = 0; fin_delay = 10;
    cyc(3);
    req_valid = 2'b00;
    wait_qsize(0, 100, "to_next_job");
    cyc(3);
    chk("to_sticky", 64'(m_to), 64'd1);
    chk("to_idle_busy", 64'(m_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
